div_seq: RTL and testbench

Sequential 32-bit radix-2 divider in the execute stage, directly upstream of the HI/LO register file. It accepts a DIV/DIVU request from EX, iterates for 32 cycles, and returns a 64-bit result: remainder in the upper word (written to HI) and quotient in the lower word (written to LO). EX holds the pipeline stalled until `ready_o` is high, then forwards the result through MEM/WB to the HI/LO write port.

---
 rtl/div_pkg.sv | 19 +
 rtl/define.sv | 18 +
 rtl/div_step.sv | 34 +++
 rtl/div_seq.sv | 163 ++++++++++++++++
 tb/tb_div_seq.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential radix-2 divider.
package div_pkg;

    // FREE: idle, SHORT: one-cycle completion, ON: iterating, END: result presented
    typedef enum logic [1:0] {
        FREE  = 2'd0,
        SHORT = 2'd1,
        ON    = 2'd2,
        END   = 2'd3
    } div_state_t;

    // One restoring step per quotient bit
    localparam int DIV_CYCLES   = 32;
    // {remainder, quotient}
    localparam int DIV_RESULT_W = 2 * DIV_CYCLES;
    // Counter must reach DIV_CYCLES itself (the finalize cycle)
    localparam int DIV_CNT_W    = $clog2(DIV_CYCLES + 1);

endpackage

// File: rtl/define.sv
// Codebase-wide level and constant defines shared by the execute-stage units.
// Each macro is guarded so this file can be compiled alongside modules that
// carry their own fallback copies without redefinition clashes.
`ifndef RstEnable
`define RstEnable 1'b1
`endif
`ifndef RstDisable
`define RstDisable 1'b0
`endif
`ifndef ChipEnable
`define ChipEnable 1'b1
`endif
`ifndef ChipDisable
`define ChipDisable 1'b0
`endif
`ifndef ZeroWord
`define ZeroWord 32'h00000000
`endif

// File: rtl/div_step.sv
// One radix-2 restoring division step (combinational).
// Working register layout: [2W:W] partial remainder, [W-1:0] dividend bits
// still to be consumed on the left and quotient bits collected on the right.
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [2*DATA_W:0]   work,
    input  logic [DATA_W-1:0]   divisor,
    output logic [2*DATA_W:0]   work_next
);

    logic [2*DATA_W+1:0] shifted;
    logic [DATA_W:0]     upper;
    logic [DATA_W:0]     diff;
    logic                borrow;
    logic                take;

    // Shift left, trial-subtract the divisor from the upper half and keep the
    // difference when it did not go negative
    always_comb begin
        shifted = {work, 1'b0};
        upper   = shifted[2*DATA_W:DATA_W];
        // 33-bit trial subtract; the extra top bit is the borrow out
        {borrow, diff} = {1'b0, upper} - {2'b00, divisor};
        // A bit shifted out past the top still means remainder >= divisor
        take = ~borrow | shifted[2*DATA_W+1];
        if (take) begin
            work_next = {diff, shifted[DATA_W-1:1], 1'b1};
        end else begin
            work_next = shifted[2*DATA_W:0];
        end
    end

endmodule

// File: rtl/div_seq.sv
// Sequential radix-2 DIV/DIVU unit feeding the HI/LO write port.
// Result is {remainder, quotient}; ready_o holds until EX drops start_i.
// Optional build macro DIV_FASTPATH_EN: operands with |dividend| < |divisor|
// finish in one cycle with quotient 0 and remainder = original dividend.
`ifndef RstEnable
`define RstEnable 1'b1
`endif

module div_seq #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    import div_pkg::*;

    div_state_t                state_reg, state_next;
    logic [DIV_CNT_W-1:0]      cnt_reg, cnt_next;
    logic [2*DATA_W:0]         work_reg, work_next;
    logic [DATA_W-1:0]         divisor_reg, divisor_next;
    logic                      neg_quot_reg, neg_quot_next;
    logic                      neg_rem_reg, neg_rem_next;
    logic [2*DATA_W-1:0]       short_res_reg, short_res_next;
    logic [2*DATA_W-1:0]       result_reg, result_next;
    logic                      ready_reg, ready_next;

    logic [DATA_W-1:0]         dividend_mag;
    logic [DATA_W-1:0]         divisor_mag;
    logic [2*DATA_W:0]         step_work;
    logic [DATA_W-1:0]         quot_raw, rem_raw;
    logic [DATA_W-1:0]         quot_fix, rem_fix;

    // Operand magnitudes: signed mode iterates on two's-complement absolutes
    assign dividend_mag = (signed_div_i && opdata1_i[DATA_W-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
    assign divisor_mag  = (signed_div_i && opdata2_i[DATA_W-1]) ? (~opdata2_i + 1'b1) : opdata2_i;

    // Raw magnitudes after the last step, and their sign-corrected forms
    assign quot_raw = work_reg[DATA_W-1:0];
    assign rem_raw  = work_reg[2*DATA_W-1:DATA_W];
    assign quot_fix = neg_quot_reg ? (~quot_raw + 1'b1) : quot_raw;
    assign rem_fix  = neg_rem_reg  ? (~rem_raw + 1'b1)  : rem_raw;

    div_step #(
        .DATA_W    (DATA_W)
    ) u_step (
        .work      (work_reg),
        .divisor   (divisor_reg),
        .work_next (step_work)
    );

    // Next-state and datapath updates; everything holds unless a branch moves it
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        work_next      = work_reg;
        divisor_next   = divisor_reg;
        neg_quot_next  = neg_quot_reg;
        neg_rem_next   = neg_rem_reg;
        short_res_next = short_res_reg;
        result_next    = result_reg;
        ready_next     = ready_reg;

        case (state_reg)
            FREE: begin
                if (start_i && !annul_i) begin
                    divisor_next   = divisor_mag;
                    neg_quot_next  = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                    neg_rem_next   = signed_div_i & opdata1_i[DATA_W-1];
                    work_next      = {{(DATA_W+1){1'b0}}, dividend_mag};
                    cnt_next       = '0;
                    short_res_next = '0;
                    if (opdata2_i == '0) begin
                        // Divide by zero: no trap, result is zero
                        state_next = SHORT;
`ifdef DIV_FASTPATH_EN
                    end else if (dividend_mag < divisor_mag) begin
                        // Quotient is trivially 0; remainder is the dividend as given
                        short_res_next = {opdata1_i, {DATA_W{1'b0}}};
                        state_next     = SHORT;
`endif
                    end else begin
                        state_next = ON;
                    end
                end
            end

            SHORT: begin
                if (annul_i) begin
                    state_next = FREE;
                end else begin
                    result_next = short_res_reg;
                    ready_next  = 1'b1;
                    state_next  = END;
                end
            end

            ON: begin
                if (annul_i) begin
                    state_next = FREE;
                end else if (cnt_reg != DIV_CNT_W'(DIV_CYCLES)) begin
                    work_next = step_work;
                    cnt_next  = cnt_reg + 1'b1;
                end else begin
                    // All quotient bits collected: apply signs and present
                    result_next = {rem_fix, quot_fix};
                    ready_next  = 1'b1;
                    state_next  = END;
                end
            end

            END: begin
                if (!start_i) begin
                    result_next = '0;
                    ready_next  = 1'b0;
                    state_next  = FREE;
                end
            end

            default: begin
                result_next = '0;
                ready_next  = 1'b0;
                state_next  = FREE;
            end
        endcase
    end

    // State and datapath registers; reset overrides start and annul
    always_ff @(posedge clk) begin
        if (rst == `RstEnable) begin
            state_reg     <= FREE;
            cnt_reg       <= '0;
            work_reg      <= '0;
            divisor_reg   <= '0;
            neg_quot_reg  <= 1'b0;
            neg_rem_reg   <= 1'b0;
            short_res_reg <= '0;
            result_reg    <= '0;
            ready_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            work_reg      <= work_next;
            divisor_reg   <= divisor_next;
            neg_quot_reg  <= neg_quot_next;
            neg_rem_reg   <= neg_rem_next;
            short_res_reg <= short_res_next;
            result_reg    <= result_next;
            ready_reg     <= ready_next;
        end
    end

    assign result_o = result_reg;
    assign ready_o  = ready_reg;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq with a cycle-level reference model and
// hand-computed literal results.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;

`ifdef DIV_FASTPATH_EN
    localparam int FAST_LAT = 1;
`else
    localparam int FAST_LAT = 33;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    div_seq #(
        .DATA_W       (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: truncating division, remainder takes dividend sign
    function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint x, y, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'd0, a});
            y = longint'({32'd0, b});
        end
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    // Edges from acceptance until ready
    function automatic int ref_lat(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint x, y;
        if (b == 32'd0) return 1;
        x = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        y = sgn ? longint'($signed(b)) : longint'({32'd0, b});
        if (x < 0) x = -x;
        if (y < 0) y = -y;
        if (x < y) return FAST_LAT;
        return 33;
    endfunction

    // Behavioural model: idle / busy with a countdown / presenting
    bit          m_live = 0;
    bit          m_busy = 0;
    bit          m_present = 0;
    int          m_left = 0;
    logic [63:0] m_res = '0;
    logic        exp_ready = 1'b0;
    logic [63:0] exp_result = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_live = 1; m_busy = 0; m_present = 0;
            exp_ready = 1'b0; exp_result = '0;
        end else if (m_busy) begin
            if (annul_i) begin
                m_busy = 0;
                exp_ready = 1'b0; exp_result = '0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0; m_present = 1;
                    exp_ready = 1'b1; exp_result = m_res;
                end
            end
        end else if (m_present) begin
            if (!start_i) begin
                m_present = 0;
                exp_ready = 1'b0; exp_result = '0;
            end
        end else if (start_i && !annul_i) begin
            m_res  = ref_div(signed_div_i, opdata1_i, opdata2_i);
            m_left = ref_lat(signed_div_i, opdata1_i, opdata2_i);
            m_busy = 1;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (m_live) begin
            check64("cyc_ready", {63'd0, ready_o}, {63'd0, exp_ready});
            check64("cyc_result", result_o, exp_result);
        end
    end

    // Wait for ready after the acceptance edge; check latency and value
    task automatic wait_ready(input string name, input int lit_lat, input logic [63:0] lit);
        int n = 0;
        logic got = 1'b0;
        while (!got && n < 60) begin
            @(posedge clk); #1;
            n++;
            got = ready_o;
        end
        check64({name, "_latency"}, 64'(n), 64'(lit_lat));
        check64({name, "_result"}, result_o, lit);
        $display("xact %s latency=%0d result=%h", name, n, result_o);
    endtask

    task automatic drop_start(input string name);
        start_i = 1'b0;
        @(posedge clk); #1;
        check64({name, "_drop_ready"}, {63'd0, ready_o}, 64'd0);
        check64({name, "_drop_result"}, result_o, 64'd0);
    endtask

    task automatic run_div(input string name, input bit sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] lit,
                           input int lit_lat, input int hold);
        check64({name, "_model"}, ref_div(sgn, a, b), lit);
        check64({name, "_model_lat"}, 64'(ref_lat(sgn, a, b)), 64'(lit_lat));
        @(posedge clk); #1;
        signed_div_i = sgn; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
        @(posedge clk); #1;
        // Operands must be captured at acceptance; scramble them now
        signed_div_i = ~sgn; opdata1_i = ~a; opdata2_i = 32'd1;
        wait_ready(name, lit_lat, lit);
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1;
            check64({name, "_hold_ready"}, {63'd0, ready_o}, 64'd1);
            check64({name, "_hold_result"}, result_o, lit);
        end
        drop_start(name);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check64("reset_ready", {63'd0, ready_o}, 64'd0);
        check64("reset_result", result_o, 64'd0);
        rst = 1'b0;

        run_div("divu_100_7",   1'b0, 32'd100,      32'd7,        64'h00000002_0000000E, 33, 5);
        run_div("div_m7_2",     1'b1, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 33, 0);
        run_div("div_7_m2",     1'b1, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33, 0);
        run_div("div_m100_m7",  1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, 33, 1);
        run_div("divu_5_0",     1'b0, 32'd5,        32'd0,        64'h00000000_00000000, 1,  2);
        run_div("div_min_m1",   1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33, 0);
        run_div("divu_max_1",   1'b0, 32'hFFFFFFFF, 32'd1,        64'h00000000_FFFFFFFF, 33, 0);
        run_div("divu_max_max", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 33, 0);
        run_div("divu_3_10",    1'b0, 32'd3,        32'd10,       64'h00000003_00000000, FAST_LAT, 2);
        run_div("div_m3_10",    1'b1, 32'hFFFFFFFD, 32'd10,       64'hFFFFFFFD_00000000, FAST_LAT, 0);

        // Annul at E10, then a fresh 9/3 accepted on the following edge
        @(posedge clk); #1;
        signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
        @(posedge clk); #1;                 // E0
        repeat (9) @(posedge clk);          // E1..E9
        #1;
        annul_i = 1'b1;
        @(posedge clk); #1;                 // E10
        check64("annul_ready", {63'd0, ready_o}, 64'd0);
        annul_i = 1'b0; opdata1_i = 32'd9; opdata2_i = 32'd3;
        @(posedge clk); #1;                 // acceptance of 9/3
        wait_ready("annul_then_9_3", 33, 64'h00000000_00000003);
        drop_start("annul_then_9_3");

        // start together with annul from idle is not accepted
        @(posedge clk); #1;
        opdata1_i = 32'd8; opdata2_i = 32'd2; start_i = 1'b1; annul_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check64("start_annul_ready", {63'd0, ready_o}, 64'd0);
        annul_i = 1'b0;
        @(posedge clk); #1;                 // acceptance
        wait_ready("div_8_2_after_annul", 33, 64'h00000000_00000004);
        drop_start("div_8_2_after_annul");

        // Reset at E20 with start held; fresh division afterwards
        @(posedge clk); #1;
        opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
        @(posedge clk); #1;                 // E0
        repeat (19) @(posedge clk);         // E1..E19
        #1;
        rst = 1'b1;
        @(posedge clk); #1;                 // E20
        check64("rst_mid_ready", {63'd0, ready_o}, 64'd0);
        check64("rst_mid_result", result_o, 64'd0);
        rst = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd5;
        @(posedge clk); #1;                 // acceptance
        wait_ready("after_rst_50_5", 33, 64'h00000000_0000000A);
        drop_start("after_rst_50_5");

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
